int_isq_slot_mgr: RTL

- Storage and bookkeeping side of the 8-entry integer issue queue: accepts up to 2 dispatched uops per cycle, allocates free slots, and tracks source-operand readiness through wakeup broadcasts.
- Maintains a per-entry relative age and presents per-entry age/request vectors to the oldest-first 8:2 issue picker.
- Consumes the picker's two grant ids, returns the granted payloads, and frees the granted slots.

---
 rtl/int_isq_slot_mgr_pkg.sv | 34 +++
 rtl/int_isq_free_finder.sv | 43 ++++
 rtl/int_isq_slot_mgr.sv | 190 +++++++++++++++++++
 3 files changed

// File: rtl/int_isq_slot_mgr_pkg.sv
// Shared definitions for the 8-entry integer issue queue slot manager.
//   INTISQ_WIDTH / INTISQ_DEPTH : slot id width and entry count
//   INTISQ_PAYLOAD_W / _TAG_W   : widths the stored entry record is built with
//   isq_entry_t                 : one queue entry (valid, age, sources, payload)
package int_isq_slot_mgr_pkg;

    localparam int unsigned INTISQ_WIDTH     = 3;
    localparam int unsigned INTISQ_DEPTH     = 8;
    localparam int unsigned INTISQ_PAYLOAD_W = 64;
    localparam int unsigned INTISQ_TAG_W     = 6;

    typedef logic [INTISQ_WIDTH-1:0] isq_id_t;
    // Ages and counts span 0..INTISQ_DEPTH, so they need one extra bit.
    typedef logic [INTISQ_WIDTH:0]   isq_cnt_t;

    typedef struct packed {
        logic                             valid;
        isq_cnt_t                         age;
        logic [1:0][INTISQ_TAG_W-1:0]     src_tag;
        logic [1:0]                       src_rdy;
        logic [INTISQ_PAYLOAD_W-1:0]      payload;
    } isq_entry_t;

    // True when either wakeup broadcast names the given tag.
    function automatic logic wake_hit(
        input logic [INTISQ_TAG_W-1:0] tag,
        input logic [1:0]              wake_valid,
        input logic [INTISQ_TAG_W-1:0] wake_tag0,
        input logic [INTISQ_TAG_W-1:0] wake_tag1
    );
        return (wake_valid[0] && (wake_tag0 == tag)) || (wake_valid[1] && (wake_tag1 == tag));
    endfunction

endpackage

// File: rtl/int_isq_free_finder.sv
// Finds the two lowest-index free slots of the issue queue.
//   i_valid  : per-slot valid bits
//   o_idx0   : lowest free slot,        o_found0 : it exists
//   o_idx1   : second-lowest free slot, o_found1 : it exists
module int_isq_free_finder
    import int_isq_slot_mgr_pkg::*;
(
    input  logic [INTISQ_DEPTH-1:0] i_valid,
    output isq_id_t                 o_idx0,
    output logic                    o_found0,
    output isq_id_t                 o_idx1,
    output logic                    o_found1
);

    isq_id_t w_idx0;
    isq_id_t w_idx1;
    logic    w_found0;
    logic    w_found1;

    always_comb begin
        w_idx0   = '0;
        w_idx1   = '0;
        w_found0 = 1'b0;
        w_found1 = 1'b0;
        for (int i = 0; i < INTISQ_DEPTH; i++) begin
            if (!i_valid[i]) begin
                if (!w_found0) begin
                    w_found0 = 1'b1;
                    w_idx0   = isq_id_t'(i);
                end else if (!w_found1) begin
                    w_found1 = 1'b1;
                    w_idx1   = isq_id_t'(i);
                end
            end
        end
    end

    assign o_idx0   = w_idx0;
    assign o_idx1   = w_idx1;
    assign o_found0 = w_found0;
    assign o_found1 = w_found1;

endmodule

// File: rtl/int_isq_slot_mgr.sv
// Storage and bookkeeping for the 8-entry integer issue queue.
//   i_clk, i_reset (async, active-high), i_flush (kill all entries)
//   i_disp_*      : two dispatch lanes (lane 0 older), o_disp_ready handshake
//   i_wake_*      : two wakeup broadcasts of destination tags
//   o_pick_age    : per-entry count of younger valid entries (larger = older)
//   o_pick_valid  : entry valid and both sources ready
//   i_issue_*     : picker grants; o_issue_payload returns the granted payloads
//   o_free_count  : registered number of free slots
module int_isq_slot_mgr
    import int_isq_slot_mgr_pkg::*;
#(
    parameter int unsigned PAYLOAD_W = INTISQ_PAYLOAD_W,
    parameter int unsigned TAG_W     = INTISQ_TAG_W
) (
    input  logic                    i_clk,
    input  logic                    i_reset,
    input  logic                    i_flush,
    input  logic [1:0]              i_disp_valid,
    output logic                    o_disp_ready,
    input  logic [PAYLOAD_W-1:0]    i_disp_payload [2],
    input  logic [TAG_W-1:0]        i_disp_src_tag [2][2],
    input  logic [1:0]              i_disp_src_rdy [2],
    input  logic [1:0]              i_wake_valid,
    input  logic [TAG_W-1:0]        i_wake_tag     [2],
    output isq_cnt_t                o_pick_age     [INTISQ_DEPTH],
    output logic [INTISQ_DEPTH-1:0] o_pick_valid,
    input  logic [1:0]              i_issue_valid,
    input  isq_id_t                 i_issue_id     [2],
    output logic [PAYLOAD_W-1:0]    o_issue_payload[2],
    output isq_cnt_t                o_free_count
);

    // The entry record is a package type, so its widths must match the parameters.
    if (PAYLOAD_W != INTISQ_PAYLOAD_W || TAG_W != INTISQ_TAG_W) begin : g_bad_width
        $error("int_isq_slot_mgr: PAYLOAD_W/TAG_W must match the package entry widths");
    end

    isq_entry_t r_entry [INTISQ_DEPTH];
    isq_cnt_t   r_free_count;

    isq_entry_t               w_entry_d [INTISQ_DEPTH];
    logic [INTISQ_DEPTH-1:0]  w_valid_vec;
    logic [INTISQ_DEPTH-1:0]  w_free_vec;
    isq_cnt_t                 w_older_freed [INTISQ_DEPTH];
    isq_cnt_t                 w_n_alloc;
    isq_cnt_t                 w_n_free;
    logic                     w_disp_ready;
    logic [1:0]               w_accept;
    logic [1:0]               w_lane_ok;
    isq_id_t                  w_lane_slot [2];
    isq_cnt_t                 w_lane_age  [2];
    logic [1:0]               w_lane_rdy  [2];
    isq_id_t                  w_idx0;
    isq_id_t                  w_idx1;
    logic                     w_found0;
    logic                     w_found1;

    always_comb begin
        for (int i = 0; i < INTISQ_DEPTH; i++) begin
            w_valid_vec[i] = r_entry[i].valid;
        end
    end

    // Allocation only looks at registered valid bits: slots freed this cycle stay
    // unavailable until the next one.
    int_isq_free_finder u_free_finder (
        .i_valid  (w_valid_vec),
        .o_idx0   (w_idx0),
        .o_found0 (w_found0),
        .o_idx1   (w_idx1),
        .o_found1 (w_found1)
    );

    assign w_disp_ready = (r_free_count >= isq_cnt_t'(2));
    assign w_accept     = i_disp_valid & {2{w_disp_ready}};
    assign w_n_alloc    = isq_cnt_t'(w_accept[0]) + isq_cnt_t'(w_accept[1]);

    // Lane 1 takes the lowest free slot when lane 0 is not accepted. The older
    // lane gets age 1 only when both lanes land together.
    always_comb begin
        w_lane_slot[0] = w_idx0;
        w_lane_slot[1] = w_accept[0] ? w_idx1 : w_idx0;
        w_lane_ok[0]   = w_accept[0] && w_found0;
        w_lane_ok[1]   = w_accept[1] && (w_accept[0] ? w_found1 : w_found0);
        w_lane_age[0]  = w_accept[1] ? isq_cnt_t'(1) : isq_cnt_t'(0);
        w_lane_age[1]  = isq_cnt_t'(0);
        for (int k = 0; k < 2; k++) begin
            for (int s = 0; s < 2; s++) begin
                w_lane_rdy[k][s] = i_disp_src_rdy[k][s] ||
                    wake_hit(i_disp_src_tag[k][s], i_wake_valid, i_wake_tag[0], i_wake_tag[1]);
            end
        end
    end

    // A grant frees a slot only if the slot holds a live entry; a doubled grant on
    // the same slot collapses into one bit here, so it is freed once.
    always_comb begin
        w_n_free = '0;
        for (int i = 0; i < INTISQ_DEPTH; i++) begin
            w_free_vec[i] = r_entry[i].valid &&
                ((i_issue_valid[0] && (i_issue_id[0] == isq_id_t'(i))) ||
                 (i_issue_valid[1] && (i_issue_id[1] == isq_id_t'(i))));
            w_n_free = w_n_free + isq_cnt_t'(w_free_vec[i]);
        end
    end

    // Each survivor loses one age step per freed entry younger than itself.
    always_comb begin
        for (int i = 0; i < INTISQ_DEPTH; i++) begin
            w_older_freed[i] = '0;
            for (int j = 0; j < INTISQ_DEPTH; j++) begin
                if (w_free_vec[j] && (r_entry[j].age < r_entry[i].age)) begin
                    w_older_freed[i] = w_older_freed[i] + isq_cnt_t'(1);
                end
            end
        end
    end

    always_comb begin
        for (int i = 0; i < INTISQ_DEPTH; i++) begin
            w_entry_d[i] = r_entry[i];
            if (r_entry[i].valid) begin
                if (w_free_vec[i]) begin
                    w_entry_d[i].valid   = 1'b0;
                    w_entry_d[i].age     = '0;
                    w_entry_d[i].src_rdy = '0;
                end else begin
                    w_entry_d[i].age = r_entry[i].age + w_n_alloc - w_older_freed[i];
                    for (int s = 0; s < 2; s++) begin
                        if (wake_hit(r_entry[i].src_tag[s], i_wake_valid,
                                     i_wake_tag[0], i_wake_tag[1])) begin
                            w_entry_d[i].src_rdy[s] = 1'b1;
                        end
                    end
                end
            end
            for (int k = 0; k < 2; k++) begin
                if (w_lane_ok[k] && (w_lane_slot[k] == isq_id_t'(i))) begin
                    w_entry_d[i].valid      = 1'b1;
                    w_entry_d[i].age        = w_lane_age[k];
                    w_entry_d[i].src_tag[0] = i_disp_src_tag[k][0];
                    w_entry_d[i].src_tag[1] = i_disp_src_tag[k][1];
                    w_entry_d[i].src_rdy    = w_lane_rdy[k];
                    w_entry_d[i].payload    = i_disp_payload[k];
                end
            end
        end
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_entry      <= '{default: '0};
            r_free_count <= isq_cnt_t'(INTISQ_DEPTH);
        end else if (i_flush) begin
            r_entry      <= '{default: '0};
            r_free_count <= isq_cnt_t'(INTISQ_DEPTH);
        end else begin
            r_entry      <= w_entry_d;
            r_free_count <= r_free_count - w_n_alloc + w_n_free;
        end
    end

    always_comb begin
        for (int i = 0; i < INTISQ_DEPTH; i++) begin
            o_pick_valid[i] = r_entry[i].valid && (&r_entry[i].src_rdy);
            o_pick_age[i]   = r_entry[i].age;
        end
    end

    assign o_issue_payload[0] = r_entry[i_issue_id[0]].payload;
    assign o_issue_payload[1] = r_entry[i_issue_id[1]].payload;
    assign o_disp_ready       = w_disp_ready;
    assign o_free_count       = r_free_count;

`ifndef SYNTHESIS
    always @(posedge i_clk) begin
        if (!i_reset && !i_flush) begin
            for (int k = 0; k < 2; k++) begin
                if (i_issue_valid[k]) begin
                    assert (r_entry[i_issue_id[k]].valid)
                    else $error("int_isq_slot_mgr: grant %0d to empty slot %0d", k, i_issue_id[k]);
                end
            end
            assert (!(&i_issue_valid && (i_issue_id[0] == i_issue_id[1])))
            else $error("int_isq_slot_mgr: both grants name slot %0d", i_issue_id[0]);
        end
    end
`endif

endmodule
